exec_sequencer: RTL and testbench

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

---
 rtl/exec_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_exec_sequencer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// exec_sequencer
// ---------------------------------------------------------------------------
// Sits between decode and the execute unit. Decoded ops are buffered in a
// 2-entry FIFO and issued one per cycle as a single-cycle strobe on ex_*.
// A DIV holds the execute unit for DIV_CYCLES cycles. A PC-writing branch
// (add/branch with dest 0) squashes whatever is queued behind it. An
// external flush empties the buffer and aborts any DIV wait.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid_i          decoded op offered
//   in_ready_o          buffer has room (count < 2)
//   in_sel_i            circuit select code
//   in_dest_i           destination register
//   in_reg3_i           second destination (DIV remainder)
//   in_reg1_i/in_reg2_i operands
//   in_inc_i            carry-in
//   flush_i             pipeline flush
//   ex_valid_o          one-cycle issue strobe
//   ex_sel_o .. ex_inc_o  registered fields of the last issued op
//   busy_o              buffer non-empty or FSM not idle
//   dbg_state_o         current FSM state (0 IDLE, 1 DIV_WAIT, 2 BR_SHADOW)
//
// Handshake: an op transfers on a rising edge where in_valid_i && in_ready_o.
// in_ready_o depends only on the buffer occupancy, never on in_valid_i, and
// there is no same-cycle pass-through when the buffer is full. The producer
// must hold its op stable until it transfers. ex_valid_o has no back-pressure:
// the execute unit must take the op in the cycle it is strobed.
// ---------------------------------------------------------------------------
module exec_sequencer #(
  parameter int unsigned DIV_CYCLES = 34
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [4:0]  in_sel_i,
  input  logic [4:0]  in_dest_i,
  input  logic [4:0]  in_reg3_i,
  input  logic [31:0] in_reg1_i,
  input  logic [31:0] in_reg2_i,
  input  logic        in_inc_i,
  input  logic        flush_i,
  output logic        ex_valid_o,
  output logic [4:0]  ex_sel_o,
  output logic [4:0]  ex_dest_o,
  output logic [31:0] ex_reg3_o,
  output logic [31:0] ex_reg1_o,
  output logic [31:0] ex_reg2_o,
  output logic        ex_inc_o,
  output logic        busy_o,
  output logic [1:0]  dbg_state_o
);

  localparam logic [4:0] SEL_ADD  = 5'b00001;
  localparam logic [4:0] SEL_DIV  = 5'b01000;
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DIV_WAIT  = 2'd1,
    ST_BR_SHADOW = 2'd2
  } state_e;

  typedef struct packed {
    logic [4:0]  sel;
    logic [4:0]  dest;
    logic [4:0]  reg3;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic        inc;
  } op_t;

  state_e     state_q, state_d;
  logic [5:0] div_cnt_q, div_cnt_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       ex_valid_q, ex_valid_d;
  op_t        ex_op_q, ex_op_d;
  op_t        fifo_mem_q [0:1];
  logic       mem_we;

  op_t  in_op;
  op_t  head;
  logic push;
  logic issue;

  assign in_op = '{sel: in_sel_i, dest: in_dest_i, reg3: in_reg3_i,
                   reg1: in_reg1_i, reg2: in_reg2_i, inc: in_inc_i};
  assign head  = fifo_mem_q[rd_ptr_q];

  assign in_ready_o = (count_q < 2'd2);
  assign push       = in_valid_i && in_ready_o;
  // Issue only from IDLE; a flush on the same edge wins.
  assign issue      = (state_q == ST_IDLE) && (count_q != 2'd0) && !flush_i;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      div_cnt_q <= 6'd0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    if (flush_i) begin
      state_d   = ST_IDLE;
      div_cnt_d = 6'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            if (head.sel == SEL_DIV) begin
              state_d   = ST_DIV_WAIT;
              div_cnt_d = DIV_LOAD;
            end else if (head.sel == SEL_ADD && head.dest == 5'd0) begin
              state_d = ST_BR_SHADOW;
            end
          end
        end
        ST_DIV_WAIT: begin
          // Leave on the edge the counter reaches zero, so the next op
          // issues exactly DIV_CYCLES cycles after the DIV strobe.
          div_cnt_d = div_cnt_q - 6'd1;
          if (div_cnt_q <= 6'd1) begin
            state_d = ST_IDLE;
          end
        end
        ST_BR_SHADOW: state_d = ST_IDLE;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    busy_o      = (count_q != 2'd0) || (state_q != ST_IDLE);
    dbg_state_o = state_q;
  end

  // FIFO bookkeeping and issue register
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mem_we     = 1'b0;
    ex_valid_d = issue;
    ex_op_d    = issue ? head : ex_op_q;
    if (flush_i) begin
      // Empty the buffer; a simultaneous push is dropped.
      rd_ptr_d = wr_ptr_q;
      count_d  = 2'd0;
    end else begin
      if (state_q == ST_BR_SHADOW) begin
        // Squash wrong-path ops; a push on this edge survives below.
        rd_ptr_d = wr_ptr_q;
        count_d  = 2'd0;
      end else if (issue) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        count_d  = count_q - 2'd1;
      end
      if (push) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_d + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
    end
  end

  // Storage needs no reset: count_q gates every read.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      fifo_mem_q[wr_ptr_q] <= in_op;
    end
  end

  assign ex_valid_o = ex_valid_q;
  assign ex_sel_o   = ex_op_q.sel;
  assign ex_dest_o  = ex_op_q.dest;
  assign ex_reg3_o  = {27'd0, ex_op_q.reg3};
  assign ex_reg1_o  = ex_op_q.reg1;
  assign ex_reg2_o  = ex_op_q.reg2;
  assign ex_inc_o   = ex_op_q.inc;

endmodule

// File: tb/tb_exec_sequencer.sv
module tb_exec_sequencer;

  localparam int DIV_CYCLES = 34;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [4:0]  in_sel_i;
  logic [4:0]  in_dest_i;
  logic [4:0]  in_reg3_i;
  logic [31:0] in_reg1_i;
  logic [31:0] in_reg2_i;
  logic        in_inc_i;
  logic        flush_i;
  logic        ex_valid_o;
  logic [4:0]  ex_sel_o;
  logic [4:0]  ex_dest_o;
  logic [31:0] ex_reg3_o;
  logic [31:0] ex_reg1_o;
  logic [31:0] ex_reg2_o;
  logic        ex_inc_o;
  logic        busy_o;
  logic [1:0]  dbg_state_o;

  always #5 clk = ~clk;

  exec_sequencer #(.DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_sel_i(in_sel_i), .in_dest_i(in_dest_i), .in_reg3_i(in_reg3_i),
    .in_reg1_i(in_reg1_i), .in_reg2_i(in_reg2_i), .in_inc_i(in_inc_i),
    .flush_i(flush_i),
    .ex_valid_o(ex_valid_o), .ex_sel_o(ex_sel_o), .ex_dest_o(ex_dest_o),
    .ex_reg3_o(ex_reg3_o), .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o),
    .ex_inc_o(ex_inc_o), .busy_o(busy_o), .dbg_state_o(dbg_state_o)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  typedef struct {
    logic [4:0]  sel;
    logic [4:0]  dest;
    logic [4:0]  reg3;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        inc;
  } op_t;

  // ---------------- reference model ----------------
  // Queue of buffered ops, remaining stall cycles after a DIV, and a flag
  // saying the next edge discards the queue (branch shadow).
  op_t m_fifo[$];
  int  m_wait;
  bit  m_shadow;
  bit  m_valid;
  op_t m_ex;

  function automatic op_t mk(input logic [4:0] sel, input logic [4:0] dest,
                             input logic [4:0] reg3, input logic [31:0] r1,
                             input logic [31:0] r2, input logic inc);
    op_t o;
    o.sel = sel; o.dest = dest; o.reg3 = reg3; o.r1 = r1; o.r2 = r2; o.inc = inc;
    return o;
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_wait   = 0;
    m_shadow = 0;
    m_valid  = 0;
    m_ex     = mk(5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input op_t o);
    in_valid_i = v;
    in_sel_i   = o.sel;
    in_dest_i  = o.dest;
    in_reg3_i  = o.reg3;
    in_reg1_i  = o.r1;
    in_reg2_i  = o.r2;
    in_inc_i   = o.inc;
  endtask

  task automatic idle_in();
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
  endtask

  // Advance the model by one edge using the inputs currently driven, then
  // let the DUT take the same edge. Outputs are sampled 1 ns after the edge.
  task automatic cycle();
    bit  push;
    op_t in_op;
    push  = in_valid_i && (m_fifo.size() < 2);
    in_op = mk(in_sel_i, in_dest_i, in_reg3_i, in_reg1_i, in_reg2_i, in_inc_i);
    m_valid = 0;
    if (flush_i) begin
      m_fifo.delete();
      m_wait   = 0;
      m_shadow = 0;
    end else begin
      if (m_shadow) begin
        m_fifo.delete();
        m_shadow = 0;
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (m_fifo.size() > 0) begin
        m_ex    = m_fifo.pop_front();
        m_valid = 1;
        if (m_ex.sel == 5'b01000) m_wait = DIV_CYCLES - 1;
        else if (m_ex.sel == 5'b00001 && m_ex.dest == 5'd0) m_shadow = 1;
      end
      if (push) m_fifo.push_back(in_op);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [1:0] m_state();
    if (m_shadow) return 2'd2;
    if (m_wait > 0) return 2'd1;
    return 2'd0;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    drive(1'b0, mk(5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    tests_run++;
    if (ex_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_ex_valid: got %0b expected 0", ex_valid_o); end
    tests_run++;
    if (in_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %0b expected 1", in_ready_o); end
    tests_run++;
    if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b expected 0", busy_o); end
    tests_run++;
    if ({ex_sel_o, ex_dest_o, ex_reg3_o, ex_reg1_o, ex_reg2_o, ex_inc_o} !== '0) begin
      tests_failed++; $display("FAIL reset_ex_data: got sel %0h r1 %0h r2 %0h expected all 0", ex_sel_o, ex_reg1_o, ex_reg2_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    op_t a;
    a = mk(5'b00010, 5'd5, 5'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1);
    drive(1'b1, a);
    cycle();                      // edge 1: accepted
    idle_in();
    tests_run++;
    if (ex_valid_o !== 1'b0) begin tests_failed++; $display("FAIL single_early: got ex_valid %0b expected 0", ex_valid_o); end
    cycle();                      // edge 2: issued
    tests_run++;
    if (ex_valid_o !== 1'b1 || ex_sel_o !== 5'b00010 || ex_dest_o !== 5'd5 ||
        ex_reg1_o !== 32'hF0F0_F0F0 || ex_reg2_o !== 32'h0FF0_0FF0 || ex_inc_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_issue: got v %0b sel %0h dest %0d r1 %0h r2 %0h inc %0b expected v 1 sel 2 dest 5 r1 f0f0f0f0 r2 ff00ff0 inc 1",
               ex_valid_o, ex_sel_o, ex_dest_o, ex_reg1_o, ex_reg2_o, ex_inc_o);
    end
    cycle();
    tests_run++;
    if (ex_valid_o !== 1'b0 || busy_o !== 1'b0 || ex_reg1_o !== 32'hF0F0_F0F0) begin
      tests_failed++;
      $display("FAIL single_after: got v %0b busy %0b r1 %0h expected v 0 busy 0 r1 f0f0f0f0", ex_valid_o, busy_o, ex_reg1_o);
    end
  endtask

  task automatic test_div();
    int div_cyc;
    int or_cyc;
    div_cyc = -1;
    or_cyc  = -1;
    drive(1'b1, mk(5'b01000, 5'd3, 5'd4, 32'd7, 32'd100, 1'b0));
    cycle();
    drive(1'b1, mk(5'b00011, 5'd9, 5'd0, $urandom, $urandom, 1'b0));
    cycle();
    idle_in();
    tests_run++;
    if (ex_valid_o !== 1'b1 || ex_sel_o !== 5'b01000 || ex_dest_o !== 5'd3 || ex_reg3_o !== 32'd4 ||
        ex_reg1_o !== 32'd7 || ex_reg2_o !== 32'd100) begin
      tests_failed++;
      $display("FAIL div_issue: got v %0b sel %0h dest %0d reg3 %0d r1 %0d r2 %0d expected v 1 sel 8 dest 3 reg3 4 r1 7 r2 100",
               ex_valid_o, ex_sel_o, ex_dest_o, ex_reg3_o, ex_reg1_o, ex_reg2_o);
    end
    div_cyc = cyc;
    for (int i = 0; i < 3 * DIV_CYCLES && or_cyc < 0; i++) begin
      cycle();
      if (i == 0) begin
        tests_run++;
        if (dbg_state_o !== 2'd1 || busy_o !== 1'b1) begin
          tests_failed++; $display("FAIL div_wait_state: got state %0d busy %0b expected 1 1", dbg_state_o, busy_o);
        end
      end
      if (ex_valid_o === 1'b1) or_cyc = cyc;
    end
    tests_run++;
    if (or_cyc - div_cyc !== DIV_CYCLES || ex_sel_o !== 5'b00011) begin
      tests_failed++;
      $display("FAIL div_latency: got gap %0d sel %0h expected gap %0d sel 3", or_cyc - div_cyc, ex_sel_o, DIV_CYCLES);
    end
    cycle();
  endtask

  task automatic test_back_to_back();
    logic [4:0] got_sel[$];
    int         got_cyc[$];
    op_t        ops[3];
    bit         acc;
    ops[0] = mk(5'b00010, 5'd7,  5'd0, $urandom, $urandom, 1'b0);
    ops[1] = mk(5'b00011, 5'd8,  5'd0, $urandom, $urandom, 1'b1);
    ops[2] = mk(5'b00000, 5'd10, 5'd0, $urandom, $urandom, 1'b0);
    // A DIV in front stalls issue so the buffer fills up.
    drive(1'b1, mk(5'b01000, 5'd1, 5'd2, 32'd9, 32'd3, 1'b0));
    cycle();
    drive(1'b1, ops[0]);
    cycle();                      // DIV issued, ops[0] accepted
    drive(1'b1, ops[1]);
    cycle();                      // ops[1] accepted, buffer full
    tests_run++;
    if (in_ready_o !== 1'b0) begin tests_failed++; $display("FAIL b2b_full_ready: got %0b expected 0", in_ready_o); end
    drive(1'b1, ops[2]);
    for (int i = 0; i < 3 * DIV_CYCLES; i++) begin
      acc = in_ready_o && in_valid_i;
      cycle();
      if (acc) in_valid_i = 1'b0;
      if (ex_valid_o === 1'b1) begin
        got_sel.push_back(ex_sel_o);
        got_cyc.push_back(cyc);
      end
    end
    tests_run++;
    if (got_sel.size() !== 3) begin
      tests_failed++; $display("FAIL b2b_count: got %0d strobes expected 3", got_sel.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (got_sel[k] !== ops[k].sel || (k > 0 && got_cyc[k] !== got_cyc[k-1] + 1)) begin
          tests_failed++;
          $display("FAIL b2b_order_%0d: got sel %0h at cycle %0d expected sel %0h consecutive", k, got_sel[k], got_cyc[k], ops[k].sel);
        end
      end
    end
  endtask

  task automatic test_branch();
    int strobes;
    strobes = 0;
    drive(1'b1, mk(5'b00001, 5'd0, 5'd0, 32'h100, 32'h4, 1'b0));
    cycle();
    drive(1'b1, mk(5'b00010, 5'd6, 5'd0, 32'h11, 32'h22, 1'b0));
    cycle();                      // branch issued, wrong-path op accepted
    tests_run++;
    if (ex_valid_o !== 1'b1 || ex_sel_o !== 5'b00001 || dbg_state_o !== 2'd2) begin
      tests_failed++; $display("FAIL br_issue: got v %0b sel %0h state %0d expected 1 1 2", ex_valid_o, ex_sel_o, dbg_state_o);
    end
    drive(1'b1, mk(5'b00011, 5'd12, 5'd0, 32'h33, 32'h44, 1'b0));
    cycle();                      // shadow edge: queue squashed, this push kept
    idle_in();
    tests_run++;
    if (ex_valid_o !== 1'b0 || dbg_state_o !== 2'd0 || busy_o !== 1'b1) begin
      tests_failed++; $display("FAIL br_shadow: got v %0b state %0d busy %0b expected 0 0 1", ex_valid_o, dbg_state_o, busy_o);
    end
    cycle();
    tests_run++;
    if (ex_valid_o !== 1'b1 || ex_sel_o !== 5'b00011 || ex_reg1_o !== 32'h33) begin
      tests_failed++; $display("FAIL br_kept_push: got v %0b sel %0h r1 %0h expected 1 3 33", ex_valid_o, ex_sel_o, ex_reg1_o);
    end
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (ex_valid_o === 1'b1) strobes++;
    end
    tests_run++;
    if (strobes !== 0 || busy_o !== 1'b0) begin
      tests_failed++; $display("FAIL br_drained: got %0d strobes busy %0b expected 0 0", strobes, busy_o);
    end
  endtask

  task automatic test_flush();
    int strobes;
    strobes = 0;
    drive(1'b1, mk(5'b01000, 5'd2, 5'd3, 32'd50, 32'd5, 1'b0));
    cycle();
    drive(1'b1, mk(5'b00010, 5'd4, 5'd0, 32'd1, 32'd2, 1'b0));
    cycle();
    drive(1'b1, mk(5'b00011, 5'd5, 5'd0, 32'd3, 32'd4, 1'b0));
    cycle();
    drive(1'b1, mk(5'b00000, 5'd6, 5'd0, 32'd5, 32'd6, 1'b0));
    flush_i = 1'b1;
    cycle();
    idle_in();
    tests_run++;
    if (busy_o !== 1'b0 || dbg_state_o !== 2'd0 || in_ready_o !== 1'b1 || ex_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_div: got busy %0b state %0d ready %0b v %0b expected 0 0 1 0", busy_o, dbg_state_o, in_ready_o, ex_valid_o);
    end
    // Flush with room in the buffer: the simultaneous push is dropped.
    drive(1'b1, mk(5'b00010, 5'd9, 5'd0, 32'd7, 32'd8, 1'b0));
    flush_i = 1'b1;
    cycle();
    idle_in();
    for (int i = 0; i < DIV_CYCLES + 4; i++) begin
      if (i == 0) begin
        tests_run++;
        if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL flush_drop_push: got busy %0b expected 0", busy_o); end
      end
      cycle();
      if (ex_valid_o === 1'b1) strobes++;
    end
    tests_run++;
    if (strobes !== 0) begin tests_failed++; $display("FAIL flush_no_strobe: got %0d strobes expected 0", strobes); end
  endtask

  task automatic test_rst_mid_div();
    drive(1'b1, mk(5'b01000, 5'd2, 5'd3, 32'd50, 32'd5, 1'b1));
    cycle();
    drive(1'b1, mk(5'b00010, 5'd4, 5'd0, 32'd1, 32'd2, 1'b0));
    cycle();
    drive(1'b1, mk(5'b00011, 5'd5, 5'd0, 32'd3, 32'd4, 1'b0));
    cycle();
    idle_in();
    tests_run++;
    if (in_ready_o !== 1'b0 || busy_o !== 1'b1) begin
      tests_failed++; $display("FAIL rst_setup: got ready %0b busy %0b expected 0 1", in_ready_o, busy_o);
    end
    #2 rst = 1'b1;                // mid-cycle, away from any edge
    #1;
    tests_run++;
    if (ex_valid_o !== 1'b0 || in_ready_o !== 1'b1 || busy_o !== 1'b0 || dbg_state_o !== 2'd0 ||
        {ex_sel_o, ex_dest_o, ex_reg3_o, ex_reg1_o, ex_reg2_o, ex_inc_o} !== '0) begin
      tests_failed++;
      $display("FAIL rst_async: got v %0b ready %0b busy %0b state %0d sel %0h r1 %0h expected 0 1 0 0 0 0",
               ex_valid_o, in_ready_o, busy_o, dbg_state_o, ex_sel_o, ex_reg1_o);
    end
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      tests_run++;
      if (ex_valid_o !== 1'b0) begin tests_failed++; $display("FAIL rst_no_strobe: got %0b expected 0", ex_valid_o); end
    end
  endtask

  task automatic test_random();
    logic [4:0] sel_tab[6];
    op_t        o;
    int         r;
    sel_tab = '{5'b00001, 5'b00000, 5'b00010, 5'b00011, 5'b00110, 5'b00111};
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 19);
      o = mk(sel_tab[$urandom_range(0, 5)], 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             $urandom, $urandom, 1'($urandom_range(0, 1)));
      if (r == 0) o.sel = 5'b01000;
      else if (r <= 3) begin o.sel = 5'b00001; o.dest = 5'd0; end
      drive($urandom_range(0, 99) < 70, o);
      flush_i = ($urandom_range(0, 99) < 3);
      cycle();
      tests_run++;
      if (ex_valid_o !== m_valid || in_ready_o !== (m_fifo.size() < 2) ||
          busy_o !== (m_fifo.size() != 0 || m_wait > 0 || m_shadow) || dbg_state_o !== m_state()) begin
        tests_failed++;
        $display("FAIL rand_ctrl cycle %0d: got v %0b ready %0b busy %0b state %0d expected v %0b ready %0b busy %0b state %0d",
                 cyc, ex_valid_o, in_ready_o, busy_o, dbg_state_o, m_valid, m_fifo.size() < 2,
                 (m_fifo.size() != 0 || m_wait > 0 || m_shadow), m_state());
      end
      tests_run++;
      if (ex_sel_o !== m_ex.sel || ex_dest_o !== m_ex.dest || ex_reg3_o !== {27'd0, m_ex.reg3} ||
          ex_reg1_o !== m_ex.r1 || ex_reg2_o !== m_ex.r2 || ex_inc_o !== m_ex.inc) begin
        tests_failed++;
        $display("FAIL rand_data cycle %0d: got sel %0h dest %0d r1 %0h r2 %0h expected sel %0h dest %0d r1 %0h r2 %0h",
                 cyc, ex_sel_o, ex_dest_o, ex_reg1_o, ex_reg2_o, m_ex.sel, m_ex.dest, m_ex.r1, m_ex.r2);
      end
    end
    idle_in();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_div();
    test_back_to_back();
    test_branch();
    test_flush();
    test_rst_mid_div();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
